// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SEND  = 3'd2,
      S_ACK   = 3'd3,
      S_DRAIN = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   localparam logic [7:0]  CR          = 8'h0D;
   localparam logic [7:0]  LF          = 8'h0A;
   localparam int unsigned ACK_TIMEOUT = 2;
   localparam int unsigned IDX_W       = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
module rr_arbiter #(
   parameter  int unsigned N  = 2,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   int unsigned cand;
   logic        found;

   // Scan requesters starting at ptr, wrapping modulo N
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= N) cand = cand - N;
         if (en && !found && req[IW'(cand)]) begin
            gnt[IW'(cand)] = 1'b1;
            gnt_idx        = IW'(cand);
            found          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin frame scheduler in front of a single 8N1 transmitter.
// Optional XOR checksum byte before CR when UART_SCHED_CHECKSUM_EN is defined.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int unsigned NREQ          = 2,
   parameter int unsigned PAYLOAD_BYTES = 5,
   parameter logic [7:0]  HDR_BASE      = 8'h61
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NREQ-1:0]                 req,
   input  logic [NREQ*PAYLOAD_BYTES*8-1:0] payload,
   output logic [NREQ-1:0]                 grant,
   output logic [NREQ-1:0]                 done,
   output logic                            active,
   output logic                            tx_start,
   output logic [7:0]                      tx_data,
   input  logic                            tx_busy
);

   localparam int unsigned PW = PAYLOAD_BYTES * 8;
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef UART_SCHED_CHECKSUM_EN
   localparam int unsigned FRAME_LEN = PAYLOAD_BYTES + 4;
`else
   localparam int unsigned FRAME_LEN = PAYLOAD_BYTES + 3;
`endif
   localparam int unsigned CR_IDX = FRAME_LEN - 2;

   // The 4-bit byte index must never wrap within a frame
   if (FRAME_LEN > 16) begin : g_frame_len_chk
      $error("uart_tx_scheduler: FRAME_LEN %0d exceeds 16", FRAME_LEN);
   end
   if (NREQ < 1 || NREQ > 4) begin : g_nreq_chk
      $error("uart_tx_scheduler: NREQ %0d outside 1..4", NREQ);
   end

   state_t            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              active_q, active_d;
   logic              tx_start_q, tx_start_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [IW-1:0]     gidx_q, gidx_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        ack_cnt_q, ack_cnt_d;
   logic [PW-1:0]     shreg_q, shreg_d;
`ifdef UART_SCHED_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif
   logic [NREQ-1:0]   arb_gnt;
   logic [IW-1:0]     arb_idx;
   logic [IDX_W-1:0]  idx_nxt;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .en      (state_q == S_IDLE),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         done_q     <= '0;
         active_q   <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         gidx_q     <= '0;
         ptr_q      <= '0;
         idx_q      <= '0;
         ack_cnt_q  <= '0;
         shreg_q    <= '0;
`ifdef UART_SCHED_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         active_q   <= active_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         gidx_q     <= gidx_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         ack_cnt_q  <= ack_cnt_d;
         shreg_q    <= shreg_d;
`ifdef UART_SCHED_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   // Next-state, byte sequencing and handshake control
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      done_d     = '0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      gidx_d     = gidx_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      ack_cnt_d  = ack_cnt_q;
      shreg_d    = shreg_q;
`ifdef UART_SCHED_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      idx_nxt    = idx_q + IDX_W'(1);

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               grant_d = arb_gnt;
               gidx_d  = arb_idx;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            shreg_d   = payload[PW*32'(gidx_q) +: PW];
            idx_d     = '0;
            tx_data_d = HDR_BASE + 8'(gidx_q);
`ifdef UART_SCHED_CHECKSUM_EN
            csum_d    = HDR_BASE + 8'(gidx_q);
`endif
            state_d   = S_SEND;
         end
         S_SEND: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               ack_cnt_d  = '0;
               state_d    = S_ACK;
            end
         end
         S_ACK: begin
            // Proceed on busy, or after the timeout in case the handshake is lost
            if (tx_busy || 32'(ack_cnt_q) == ACK_TIMEOUT - 1) begin
               state_d = S_DRAIN;
            end else begin
               ack_cnt_d = ack_cnt_q + 2'd1;
            end
         end
         S_DRAIN: begin
            if (!tx_busy) begin
               if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                  state_d = S_FIN;
               end else begin
                  idx_d   = idx_nxt;
                  state_d = S_SEND;
                  if (idx_nxt <= IDX_W'(PAYLOAD_BYTES)) begin
                     tx_data_d = shreg_q[7:0];
                     shreg_d   = shreg_q >> 8;
`ifdef UART_SCHED_CHECKSUM_EN
                     csum_d    = csum_q ^ shreg_q[7:0];
                  end else if (idx_nxt == IDX_W'(PAYLOAD_BYTES + 1)) begin
                     tx_data_d = csum_q;
`endif
                  end else if (idx_nxt == IDX_W'(CR_IDX)) begin
                     tx_data_d = CR;
                  end else begin
                     tx_data_d = LF;
                  end
               end
            end
         end
         S_FIN: begin
            done_d  = grant_q;
            grant_d = '0;
            ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      active_d = (state_d != S_IDLE);
   end

   assign grant    = grant_q;
   assign done     = done_q;
   assign active   = active_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a busy/start transmitter model.
module tb_uart_tx_scheduler;

   localparam int unsigned NREQ = 2;
   localparam int unsigned PB   = 5;
   localparam int unsigned PW   = PB * 8;
   localparam logic [7:0]  HDR  = 8'h61;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*PW-1:0] payload = '0;
   logic [NREQ-1:0]    grant, done;
   logic               active, tx_start;
   logic [7:0]         tx_data;
   logic               tx_busy = 1'b0;

   uart_tx_scheduler #(.NREQ(NREQ), .PAYLOAD_BYTES(PB), .HDR_BASE(HDR)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .payload  (payload),
      .grant    (grant),
      .done     (done),
      .active   (active),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy)
   );

   int checks = 0, errors = 0, cyc = 0;
   int gviol = 0, sviol = 0, model_ptr = 0;
   logic [7:0]      cap_q[$], exp_q[$];
   int              start_cyc[$];
   logic [NREQ-1:0] done_v[$], exp_done[$];
   bit              ext_busy = 1'b0, never_busy = 1'b0;
   int              busy_cnt = 0;
   bit              pend = 1'b0;

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Transmitter model: busy rises one cycle after start, held 10 cycles
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         busy_cnt = 0;
         pend     = 1'b0;
      end else begin
         if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
         if (pend) begin
            pend = 1'b0;
            if (!never_busy) busy_cnt = 10;
         end
         if (tx_start) pend = 1'b1;
      end
      tx_busy = ext_busy || (busy_cnt > 0);
   end

   // Monitor: capture transmitted bytes, done pulses, grant/start rule violations
   logic [NREQ-1:0] prev_grant = '0;
   logic            prev_active = 1'b0;
   initial forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
         cap_q.push_back(tx_data);
         start_cyc.push_back(cyc);
         if (tx_busy) sviol = sviol + 1;
      end
      if (done != '0) done_v.push_back(done);
      if (active && !$onehot(grant)) gviol = gviol + 1;
      if (!active && grant != '0) gviol = gviol + 1;
      if (prev_active && active && grant != prev_grant) gviol = gviol + 1;
      prev_grant  = grant;
      prev_active = active;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_caps();
      cap_q.delete();
      exp_q.delete();
      start_cyc.delete();
      done_v.delete();
      exp_done.delete();
   endtask

   task automatic rand_payload();
      for (int i = 0; i < int'(NREQ * PB); i++) payload[8*i +: 8] = 8'($urandom);
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] r);
      for (int i = 0; i < int'(NREQ); i++) begin
         int c;
         c = (model_ptr + i) % int'(NREQ);
         if (r[c]) return c;
      end
      return 0;
   endfunction

   // Expected frame of source k from the current payload bus
   task automatic push_frame(input int k);
      logic [7:0] b, cs;
      cs = HDR + 8'(k);
      exp_q.push_back(cs);
      for (int i = 0; i < int'(PB); i++) begin
         b  = payload[k*int'(PW) + 8*i +: 8];
         exp_q.push_back(b);
         cs = cs ^ b;
      end
`ifdef UART_SCHED_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      exp_done.push_back(NREQ'(1 << k));
      model_ptr = (k + 1) % int'(NREQ);
   endtask

   task automatic expect_frames(input logic [NREQ-1:0] r, input int n);
      for (int j = 0; j < n; j++) push_frame(rr_pick(r));
   endtask

   task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (grant == '0 && c < 10);
      check(tag, 32'(grant), 32'(exp));
   endtask

   task automatic wait_done(input string tag, input int n);
      int c = 0;
      while (done_v.size() < n && c < 400 * n) begin
         @(negedge clk);
         c++;
      end
      check(tag, 32'(done_v.size() >= n), 32'(1));
   endtask

   task automatic compare_all(input string tag);
      check($sformatf("%s_len", tag), 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
      check($sformatf("%s_ndone", tag), 32'(done_v.size()), 32'(exp_done.size()));
      for (int i = 0; i < done_v.size() && i < exp_done.size(); i++)
         check($sformatf("%s_done%0d", tag, i), 32'(done_v[i]), 32'(exp_done[i]));
   endtask

   initial begin
      int t0;
      int c;
      int mask;
      int nfr;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_grant", 32'(grant), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_active", 32'(active), 32'(0));
      check("rst_tx_start", 32'(tx_start), 32'(0));
      check("rst_tx_data", 32'(tx_data), 32'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single request, known payload, 3-cycle start latency
      payload[PW-1:0]    = 40'h0504030201;
      payload[2*PW-1:PW] = 40'hA5A5A5A5A5;
      clear_caps();
      expect_frames(2'b01, 1);
      req = 2'b01;
      t0  = cyc;
      wait_grant("t1_grant", 2'b01);
      req = 2'b00;
      wait_done("t1_done", 1);
      repeat (3) @(negedge clk);
      compare_all("t1");
      if (start_cyc.size() > 0) check("t1_latency", 32'(start_cyc[0] - t0), 32'(3));
      check("t1_idle", 32'(active), 32'(0));

      // Simultaneous requests from reset: RR order 0,1,0,1
      rst_n = 1'b0;
      model_ptr = 0;
      req = 2'b11;
      rand_payload();
      repeat (2) @(negedge clk);
      clear_caps();
      expect_frames(2'b11, 4);
      rst_n = 1'b1;
      wait_done("t2_done", 4);
      req = 2'b00;
      repeat (5) @(negedge clk);
      compare_all("t2");

      // Random request masks held for random frame counts
      for (int it = 0; it < 4; it++) begin
         mask = $urandom_range(1, (1 << NREQ) - 1);
         nfr  = $urandom_range(1, 3);
         rand_payload();
         clear_caps();
         expect_frames(NREQ'(mask), nfr);
         req = NREQ'(mask);
         wait_done($sformatf("tr%0d_done", it), nfr);
         req = 2'b00;
         repeat (5) @(negedge clk);
         compare_all($sformatf("tr%0d", it));
      end

      // Payload change after grant does not affect the latched frame
      rand_payload();
      clear_caps();
      expect_frames(2'b01, 1);
      req = 2'b01;
      wait_grant("t3_grant", 2'b01);
      @(negedge clk);
      payload[PW-1:0] = ~payload[PW-1:0];
      req = 2'b00;
      wait_done("t3_done", 1);
      repeat (3) @(negedge clk);
      compare_all("t3");

      // Lost handshake: busy never rises, start spacing is 4 cycles
      never_busy = 1'b1;
      rand_payload();
      clear_caps();
      expect_frames(2'b01, 1);
      req = 2'b01;
      wait_grant("t4_grant", 2'b01);
      req = 2'b00;
      wait_done("t4_done", 1);
      repeat (3) @(negedge clk);
      compare_all("t4");
      for (int i = 1; i < start_cyc.size(); i++)
         check($sformatf("t4_gap%0d", i), 32'(start_cyc[i] - start_cyc[i-1]), 32'(4));
      never_busy = 1'b0;
      repeat (2) @(negedge clk);

      // Transmitter held busy by an external user: no start until it frees
      ext_busy = 1'b1;
      repeat (2) @(negedge clk);
      rand_payload();
      clear_caps();
      expect_frames(2'b10, 1);
      req = 2'b10;
      repeat (20) @(negedge clk);
      req = 2'b00;
      check("te_nostart", 32'(cap_q.size()), 32'(0));
      check("te_active", 32'(active), 32'(1));
      ext_busy = 1'b0;
      wait_done("te_done", 1);
      repeat (3) @(negedge clk);
      compare_all("te");

      // Asynchronous reset during the third byte, then restart from header
      rand_payload();
      clear_caps();
      req = 2'b01;
      c = 0;
      while (cap_q.size() < 3 && c < 400) begin
         @(negedge clk);
         c++;
      end
      check("t5_start_seen", 32'(tx_start), 32'(1));
      rst_n = 1'b0;
      #1;
      check("t5_rst_tx_start", 32'(tx_start), 32'(0));
      check("t5_rst_grant", 32'(grant), 32'(0));
      check("t5_rst_done", 32'(done), 32'(0));
      check("t5_rst_active", 32'(active), 32'(0));
      req = 2'b00;
      repeat (3) @(negedge clk);
      check("t5_no_done", 32'(done_v.size()), 32'(0));
      clear_caps();
      model_ptr = 0;
      expect_frames(2'b01, 1);
      rst_n = 1'b1;
      req = 2'b01;
      wait_grant("t5_grant", 2'b01);
      req = 2'b00;
      wait_done("t5_done", 1);
      repeat (3) @(negedge clk);
      compare_all("t5");

      // Global protocol rules across the whole run
      check("grant_rule_viol", 32'(gviol), 32'(0));
      check("start_while_busy", 32'(sviol), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
